// File: rtl/wb_stage_if.sv
// Upstream instruction, register-file write and syscall signals of the writeback stage.
interface wb_stage_if #(
  parameter int REGISTER_WIDTH         = 64,
  parameter int REGISTERNO_WIDTH       = 5,
  parameter int INSTRUCTION_NAME_WIDTH = 96
);
  logic                              in_enable;
  logic                              out_ready;
  logic                              in_mm_load_bool;
  logic                              in_update_rd_bool;
  logic [REGISTERNO_WIDTH-1:0]       in_rd_regno;
  logic [REGISTER_WIDTH-1:0]         in_alu_result;
  logic [REGISTER_WIDTH-1:0]         in_mdata;
  logic [INSTRUCTION_NAME_WIDTH-1:0] in_opcode_name;
  logic                              out_rf_wr_en;
  logic [REGISTERNO_WIDTH-1:0]       out_rf_wr_regno;
  logic [REGISTER_WIDTH-1:0]         out_rf_wr_data;
  logic                              out_syscall_req;
  logic                              in_syscall_ack;
  logic [REGISTER_WIDTH-1:0]         in_syscall_result;
  logic                              out_syscall_flush;
  logic [63:0]                       out_retire_count;

  modport slave (
    input  in_enable, in_mm_load_bool, in_update_rd_bool, in_rd_regno,
           in_alu_result, in_mdata, in_opcode_name, in_syscall_ack, in_syscall_result,
    output out_ready, out_rf_wr_en, out_rf_wr_regno, out_rf_wr_data,
           out_syscall_req, out_syscall_flush, out_retire_count
  );

  modport master (
    output in_enable, in_mm_load_bool, in_update_rd_bool, in_rd_regno,
           in_alu_result, in_mdata, in_opcode_name, in_syscall_ack, in_syscall_result,
    input  out_ready, out_rf_wr_en, out_rf_wr_regno, out_rf_wr_data,
           out_syscall_req, out_syscall_flush, out_retire_count
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: 2-entry FIFO retiring one instruction per cycle (push at N, write at N+1);
// ecall stalls intake (out_ready=0) through request/ack, a0 write and a one-cycle flush.
module wb_stage #(
  parameter int REGISTER_WIDTH         = 64,
  parameter int REGISTERNO_WIDTH       = 5,
  parameter int INSTRUCTION_NAME_WIDTH = 96
) (
  input logic       clk,
  input logic       reset,
  wb_stage_if.slave bus
);
  localparam logic [INSTRUCTION_NAME_WIDTH-1:0] ECALL_NAME = INSTRUCTION_NAME_WIDTH'("ecall");
  localparam logic [REGISTERNO_WIDTH-1:0]       A0_REGNO   = REGISTERNO_WIDTH'(10);

  typedef enum logic [1:0] {IDLE, SYSREQ, WRITE_A0, FLUSH} state_t;

  typedef struct packed {
    logic                        mm_load;
    logic                        update_rd;
    logic [REGISTERNO_WIDTH-1:0] rd_regno;
    logic [REGISTER_WIDTH-1:0]   alu_result;
    logic [REGISTER_WIDTH-1:0]   mdata;
    logic                        is_ecall;
  } entry_t;

  state_t                      state_q, state_d;
  entry_t                      fifo_q [2];
  entry_t                      head, new_entry;
  logic                        rd_ptr_q, wr_ptr_q;
  logic [1:0]                  count_q;
  logic                        ready, push, pop, clear;
  logic                        wr_en_q, wr_en_d;
  logic [REGISTERNO_WIDTH-1:0] wr_regno_q, wr_regno_d;
  logic [REGISTER_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [REGISTER_WIDTH-1:0]   result_q, result_d;
  logic                        req_q, req_d;
  logic                        flush_q;
  logic [63:0]                 retire_q, retire_d;

  assign head  = fifo_q[rd_ptr_q];
  assign ready = (count_q != 2'd2) && (state_q == IDLE);
  assign push  = bus.in_enable && ready;

  always_comb begin
    new_entry.mm_load    = bus.in_mm_load_bool;
    new_entry.update_rd  = bus.in_update_rd_bool;
    new_entry.rd_regno   = bus.in_rd_regno;
    new_entry.alu_result = bus.in_alu_result;
    new_entry.mdata      = bus.in_mdata;
    new_entry.is_ecall   = (bus.in_opcode_name == ECALL_NAME);
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    clear      = 1'b0;
    wr_en_d    = 1'b0;
    wr_regno_d = wr_regno_q;
    wr_data_d  = wr_data_q;
    result_d   = result_q;
    req_d      = 1'b0;
    retire_d   = retire_q;
    case (state_q)
      IDLE: begin
        if (count_q != 2'd0) begin
          if (head.is_ecall) begin
            state_d = SYSREQ;
            req_d   = 1'b1;
          end else begin
            pop        = 1'b1;
            wr_en_d    = head.update_rd && (head.rd_regno != '0);
            wr_regno_d = head.rd_regno;
            wr_data_d  = head.mm_load ? head.mdata : head.alu_result;
            retire_d   = retire_q + 64'd1;
          end
        end
      end
      SYSREQ: begin
        req_d = 1'b1;
        if (bus.in_syscall_ack) begin
          req_d    = 1'b0;
          result_d = bus.in_syscall_result;
          state_d  = WRITE_A0;
        end
      end
      WRITE_A0: begin
        pop        = 1'b1;
        wr_en_d    = 1'b1;
        wr_regno_d = A0_REGNO;
        wr_data_d  = result_q;
        retire_d   = retire_q + 64'd1;
        state_d    = FLUSH;
      end
      FLUSH: begin
        // Younger entries behind the ecall are dropped unwritten.
        clear   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      wr_en_q    <= 1'b0;
      wr_regno_q <= '0;
      wr_data_q  <= '0;
      result_q   <= '0;
      req_q      <= 1'b0;
      flush_q    <= 1'b0;
      retire_q   <= 64'd0;
    end else begin
      state_q    <= state_d;
      wr_en_q    <= wr_en_d;
      wr_regno_q <= wr_regno_d;
      wr_data_q  <= wr_data_d;
      result_q   <= result_d;
      req_q      <= req_d;
      flush_q    <= (state_d == FLUSH);
      retire_q   <= retire_d;
      if (clear) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
        count_q  <= 2'd0;
      end else begin
        if (push) wr_ptr_q <= ~wr_ptr_q;
        if (pop)  rd_ptr_q <= ~rd_ptr_q;
        count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= new_entry;
  end

  assign bus.out_ready         = ready;
  assign bus.out_rf_wr_en      = wr_en_q;
  assign bus.out_rf_wr_regno   = wr_regno_q;
  assign bus.out_rf_wr_data    = wr_data_q;
  assign bus.out_syscall_req   = req_q;
  assign bus.out_syscall_flush = flush_q;
  assign bus.out_retire_count  = retire_q;
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed retire/ecall/reset/full scenarios and a randomized
// instruction stream compared against a queue of expected register-file writes.
module tb_wb_stage;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  localparam logic [95:0] N_ADD   = 96'("add");
  localparam logic [95:0] N_LD    = 96'("ld");
  localparam logic [95:0] N_ADDI  = 96'("addi");
  localparam logic [95:0] N_SUB   = 96'("sub");
  localparam logic [95:0] N_ECALL = 96'("ecall");

  typedef struct {
    logic        en;
    logic [4:0]  regno;
    logic [63:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         e;
  logic [63:0] exp_retire;
  logic        prev_pushed;
  logic        en, ld, upd;
  logic [4:0]  rd;
  logic [63:0] alu, md;

  wb_stage_if bus ();
  wb_stage dut (.clk(clk), .reset(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e_n, input logic [95:0] name, input logic l, input logic u,
                       input logic [4:0] r, input logic [63:0] a, input logic [63:0] m);
    bus.in_enable         = e_n;
    bus.in_opcode_name    = name;
    bus.in_mm_load_bool   = l;
    bus.in_update_rd_bool = u;
    bus.in_rd_regno       = r;
    bus.in_alu_result     = a;
    bus.in_mdata          = m;
  endtask

  // Architectural effect of retiring one non-ecall instruction.
  function automatic wr_t expect_write(input logic l, input logic u, input logic [4:0] r,
                                       input logic [63:0] a, input logic [63:0] m);
    wr_t w;
    w.en    = u && (r != 5'd0);
    w.regno = r;
    w.data  = l ? m : a;
    return w;
  endfunction

  initial begin
    drive(1'b0, N_ADD, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
    bus.in_syscall_ack    = 1'b0;
    bus.in_syscall_result = 64'd0;

    #12;
    chk("rst_ready", 64'(bus.out_ready), 64'd1);
    chk("rst_wr_en", 64'(bus.out_rf_wr_en), 64'd0);
    chk("rst_regno", 64'(bus.out_rf_wr_regno), 64'd0);
    chk("rst_data", bus.out_rf_wr_data, 64'd0);
    chk("rst_req", 64'(bus.out_syscall_req), 64'd0);
    chk("rst_flush", 64'(bus.out_syscall_flush), 64'd0);
    chk("rst_retire", bus.out_retire_count, 64'd0);
    #11 rst_n = 1'b1;
    step();

    // add: pushed at edge N, written at edge N+1
    drive(1'b1, N_ADD, 1'b0, 1'b1, 5'd5, 64'h1234, 64'hDEAD);
    step();
    chk("add_not_early", 64'(bus.out_rf_wr_en), 64'd0);
    chk("add_retire_early", bus.out_retire_count, 64'd0);
    drive(1'b0, N_ADD, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
    step();
    chk("add_wr_en", 64'(bus.out_rf_wr_en), 64'd1);
    chk("add_regno", 64'(bus.out_rf_wr_regno), 64'd5);
    chk("add_data", bus.out_rf_wr_data, 64'h1234);
    chk("add_retire", bus.out_retire_count, 64'd1);
    step();
    chk("idle_wr_en", 64'(bus.out_rf_wr_en), 64'd0);

    // ld selects mdata, then an rd=0 write is suppressed but still retires
    drive(1'b1, N_LD, 1'b1, 1'b1, 5'd7, 64'h40, 64'hFFFF_FFFF_FFFF_FF80);
    step();
    drive(1'b1, N_ADDI, 1'b0, 1'b1, 5'd0, 64'h55, 64'd0);
    step();
    chk("ld_wr_en", 64'(bus.out_rf_wr_en), 64'd1);
    chk("ld_regno", 64'(bus.out_rf_wr_regno), 64'd7);
    chk("ld_data", bus.out_rf_wr_data, 64'hFFFF_FFFF_FFFF_FF80);
    chk("ld_retire", bus.out_retire_count, 64'd2);
    drive(1'b0, N_ADD, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
    step();
    chk("rd0_wr_en", 64'(bus.out_rf_wr_en), 64'd0);
    chk("rd0_retire", bus.out_retire_count, 64'd3);

    // six back-to-back pushes, then a random stream with gaps
    exp_retire  = 64'd3;
    prev_pushed = 1'b0;
    for (int i = 0; i < 46; i++) begin
      chk("stream_ready", 64'(bus.out_ready), 64'd1);
      en  = (i < 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
      ld  = $urandom_range(0, 1) == 1;
      upd = $urandom_range(0, 3) != 0;
      rd  = 5'($urandom_range(0, 31));
      alu = {$urandom, $urandom};
      md  = {$urandom, $urandom};
      drive(en, N_ADD, ld, upd, rd, alu, md);
      if (en) exp_q.push_back(expect_write(ld, upd, rd, alu, md));
      step();
      if (prev_pushed) begin
        e = exp_q.pop_front();
        exp_retire = exp_retire + 64'd1;
        chk("stream_wr_en", 64'(bus.out_rf_wr_en), 64'(e.en));
        chk("stream_regno", 64'(bus.out_rf_wr_regno), 64'(e.regno));
        chk("stream_data", bus.out_rf_wr_data, e.data);
      end else begin
        chk("stream_gap_wr_en", 64'(bus.out_rf_wr_en), 64'd0);
      end
      chk("stream_retire", bus.out_retire_count, exp_retire);
      prev_pushed = en;
    end
    drive(1'b0, N_ADD, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
    step();
    if (prev_pushed) begin
      e = exp_q.pop_front();
      exp_retire = exp_retire + 64'd1;
      chk("stream_last_wr_en", 64'(bus.out_rf_wr_en), 64'(e.en));
      chk("stream_last_data", bus.out_rf_wr_data, e.data);
    end
    chk("stream_end_retire", bus.out_retire_count, exp_retire);
    step();

    // ecall then addi (FIFO full), a third push refused, ack after three request cycles
    drive(1'b1, N_ECALL, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
    bus.in_syscall_ack = 1'b1;
    step();
    chk("ec_req_idle", 64'(bus.out_syscall_req), 64'd0);
    drive(1'b1, N_ADDI, 1'b0, 1'b1, 5'd3, 64'h77, 64'd0);
    step();
    chk("ec_req_1", 64'(bus.out_syscall_req), 64'd1);
    chk("ec_ready_full", 64'(bus.out_ready), 64'd0);
    chk("ec_retire_hold", bus.out_retire_count, exp_retire);
    bus.in_syscall_ack = 1'b0;
    drive(1'b1, N_SUB, 1'b0, 1'b1, 5'd9, 64'h99, 64'd0);
    step();
    chk("ec_req_2", 64'(bus.out_syscall_req), 64'd1);
    chk("ec_ready_2", 64'(bus.out_ready), 64'd0);
    chk("ec_no_wr_2", 64'(bus.out_rf_wr_en), 64'd0);
    step();
    chk("ec_req_3", 64'(bus.out_syscall_req), 64'd1);
    chk("ec_ready_3", 64'(bus.out_ready), 64'd0);
    bus.in_syscall_ack    = 1'b1;
    bus.in_syscall_result = 64'h2A;
    step();
    chk("ec_req_drop", 64'(bus.out_syscall_req), 64'd0);
    chk("ec_ready_4", 64'(bus.out_ready), 64'd0);
    chk("ec_no_wr_4", 64'(bus.out_rf_wr_en), 64'd0);
    chk("ec_no_flush_4", 64'(bus.out_syscall_flush), 64'd0);
    bus.in_syscall_ack    = 1'b0;
    bus.in_syscall_result = 64'hBAD0_BAD0;
    step();
    exp_retire = exp_retire + 64'd1;
    chk("ec_a0_wr_en", 64'(bus.out_rf_wr_en), 64'd1);
    chk("ec_a0_regno", 64'(bus.out_rf_wr_regno), 64'd10);
    chk("ec_a0_data", bus.out_rf_wr_data, 64'h2A);
    chk("ec_flush", 64'(bus.out_syscall_flush), 64'd1);
    chk("ec_ready_5", 64'(bus.out_ready), 64'd0);
    chk("ec_retire", bus.out_retire_count, exp_retire);
    step();
    chk("ec_flush_once", 64'(bus.out_syscall_flush), 64'd0);
    chk("ec_post_wr_en", 64'(bus.out_rf_wr_en), 64'd0);
    chk("ec_ready_idle", 64'(bus.out_ready), 64'd1);
    drive(1'b0, N_ADD, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
    step();
    chk("ec_addi_dropped", 64'(bus.out_rf_wr_en), 64'd0);
    chk("ec_retire_final", bus.out_retire_count, exp_retire);
    chk("ec_req_final", 64'(bus.out_syscall_req), 64'd0);

    // reset asserted mid-SYSREQ clears the request without a clock edge
    drive(1'b1, N_ECALL, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
    step();
    drive(1'b0, N_ADD, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
    step();
    chk("rr_req_before", 64'(bus.out_syscall_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_req_async", 64'(bus.out_syscall_req), 64'd0);
    chk("rr_retire_async", bus.out_retire_count, 64'd0);
    chk("rr_ready_async", 64'(bus.out_ready), 64'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    chk("rr_req_after", 64'(bus.out_syscall_req), 64'd0);
    chk("rr_ready_after", 64'(bus.out_ready), 64'd1);
    chk("rr_retire_after", bus.out_retire_count, 64'd0);
    drive(1'b1, N_ADD, 1'b0, 1'b1, 5'd1, 64'hABC, 64'd0);
    step();
    drive(1'b0, N_ADD, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
    step();
    chk("rr_resume_data", bus.out_rf_wr_data, 64'hABC);
    chk("rr_resume_retire", bus.out_retire_count, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
